// File: rtl/sram_like_resp.sv
// SRAM-like bus responder: word-addressed memory with fixed LATENCY and at most DEPTH outstanding requests.
// Optional macro RESP_STALL_EN adds LFSR-driven pseudo-random back-pressure on addr_ok.
module sram_like_resp #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        addr_ok,
    output logic        data_ok
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [31:0]        r_mem [0:(1<<ADDR_W)-1];
    logic [LATENCY-1:0] r_vld;
    logic [31:0]        r_data [LATENCY];
    logic [CNT_W-1:0]   r_cnt;

    logic              w_acc;
    logic              w_stall;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_idx;
    logic              w_unused;

    assign w_idx    = addr[ADDR_W+1:2];
    assign w_unused = ^addr[31:ADDR_W+2];

    // Misaligned half/word accesses get no lanes: the write is dropped but still completes.
    always_comb begin
        w_be = 4'b0000;
        case (size)
            2'd0: w_be = 4'b0001 << addr[1:0];
            2'd1: begin
                if (addr[1:0] == 2'b00)      w_be = 4'b0011;
                else if (addr[1:0] == 2'b10) w_be = 4'b1100;
            end
            default: begin
                if (addr[1:0] == 2'b00) w_be = 4'b1111;
            end
        endcase
    end

`ifdef RESP_STALL_EN
    logic [3:0] r_lfsr;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_lfsr <= 4'b1001;
        else          r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // Gated by aresetn so no request is accepted while reset is held.
    assign addr_ok = req && aresetn && (r_cnt < C_DEPTH) && !w_stall;
    assign w_acc   = addr_ok;
    assign data_ok = r_vld[LATENCY-1];
    assign rdata   = data_ok ? r_data[LATENCY-1] : 32'd0;

    always_ff @(posedge aclk) begin
        if (w_acc && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Read word is captured at acceptance; write entries carry zero data down the line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_data[i] <= '0;
        end else begin
            r_vld[0]  <= w_acc;
            r_data[0] <= (w_acc && !wr) ? r_mem[w_idx] : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                r_cnt <= '0;
        else if (w_acc && !data_ok)  r_cnt <= r_cnt + C_ONE;
        else if (!w_acc && data_ok)  r_cnt <= r_cnt - C_ONE;
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: two instances (defaults, and LATENCY=3/DEPTH=2) checked each cycle
// against a transaction-level reference model; honours RESP_STALL_EN when defined.
module tb_sram_like_resp;

    logic        clk;
    logic        aresetn;
    logic        req_a, req_b;
    logic        wr_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_a, rdata_b;
    logic        aok_a, aok_b, dok_a, dok_b;

    int n_checks = 0;
    int n_fail   = 0;

    sram_like_resp u_dut_a (
        .aclk(clk), .aresetn(aresetn), .req(req_a), .wr(wr_i), .size(size_i),
        .addr(addr_i), .wdata(wdata_i), .rdata(rdata_a), .addr_ok(aok_a), .data_ok(dok_a)
    );

    sram_like_resp #(.ADDR_W(12), .LATENCY(3), .DEPTH(2)) u_dut_b (
        .aclk(clk), .aresetn(aresetn), .req(req_b), .wr(wr_i), .size(size_i),
        .addr(addr_i), .wdata(wdata_i), .rdata(rdata_b), .addr_ok(aok_b), .data_ok(dok_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per-instance memory image plus a list of in-flight responses with due cycles.
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] mm[2][4096];
    logic [3:0]  m_lfsr = 4'b1001;
    int          cyc = 0;
    bit          acc_a, acc_b;
    int          n_dok_a = 0, n_dok_b = 0;
    logic [31:0] last_a = '0, last_b = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_inst(input int k, input bit rq, input bit rstn, input bit wr,
                              input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                              input logic aok, input logic dok, input logic [31:0] rd,
                              output bit acc);
        int          lat   = (k == 0) ? 2 : 3;
        int          dep   = (k == 0) ? 4 : 2;
        string       pfx   = (k == 0) ? "A" : "B";
        int          outst = 0;
        bit          e_dok = 1'b0;
        logic [31:0] e_rd  = '0;
        bit          e_aok;
        int          idx   = int'((ad >> 2) & 32'hFFF);
        int          a2    = int'(ad & 32'h3);
        logic [31:0] w;
        ent_t        e;

        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].inst == k && (!rstn || pend[i].due < cyc)) pend.delete(i);
        foreach (pend[i]) begin
            if (pend[i].inst == k) begin
                outst++;
                if (pend[i].due == cyc) begin
                    e_dok = 1'b1;
                    e_rd  = pend[i].data;
                end
            end
        end
        e_aok = rstn && rq && (outst < dep);
`ifdef RESP_STALL_EN
        e_aok = e_aok && !m_lfsr[0];
`endif
        chk({pfx, ".addr_ok"}, {31'd0, aok}, {31'd0, e_aok});
        chk({pfx, ".data_ok"}, {31'd0, dok}, {31'd0, e_dok});
        chk({pfx, ".rdata"},   rd, e_rd);

        if (e_aok) begin
            e.inst = k;
            e.due  = cyc + lat;
            e.data = wr ? 32'd0 : mm[k][idx];
            pend.push_back(e);
            if (wr) begin
                w = mm[k][idx];
                case (sz)
                    2'd0: w[a2*8 +: 8] = wd[a2*8 +: 8];
                    2'd1: begin
                        if (a2 == 0)      w[15:0]  = wd[15:0];
                        else if (a2 == 2) w[31:16] = wd[31:16];
                    end
                    default: if (a2 == 0) w = wd;
                endcase
                mm[k][idx] = w;
            end
        end
        acc = e_aok;
    endtask

    task automatic step(input bit rq_a, input bit rq_b, input bit rstn, input bit wr,
                        input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        @(posedge clk);
        #1;
        req_a = rq_a; req_b = rq_b; aresetn = rstn;
        wr_i = wr; size_i = sz; addr_i = ad; wdata_i = wd;
        @(negedge clk);
        if (dok_a === 1'b1) begin n_dok_a++; last_a = rdata_a; end
        if (dok_b === 1'b1) begin n_dok_b++; last_b = rdata_b; end
        model_inst(0, rq_a, rstn, wr, sz, ad, wd, aok_a, dok_a, rdata_a, acc_a);
        model_inst(1, rq_b, rstn, wr, sz, ad, wd, aok_b, dok_b, rdata_b, acc_b);
        if (rstn) m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
        else      m_lfsr = 4'b1001;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    // Hold req on each instance until that instance has accepted the request once.
    task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] wd);
        bit da = 1'b0, db = 1'b0;
        int guard = 0;
        while (!(da && db) && guard < 64) begin
            step(!da, !db, 1'b1, wr, sz, ad, wd);
            da = da | acc_a;
            db = db | acc_b;
            guard++;
        end
        chk("issue_done", {30'd0, da, db}, 32'd3);
    endtask

    task automatic drain();
        int g = 0;
        while (pend.size() != 0 && g < 40) begin
            idle();
            g++;
        end
        chk("drain_empty", pend.size(), 0);
    endtask

    initial begin
        int n0a, n0b;
        logic [31:0] ad;

        aresetn = 1'b0; req_a = 1'b0; req_b = 1'b0;
        wr_i = 1'b0; size_i = 2'd0; addr_i = '0; wdata_i = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);
        idle();

        for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, i * 4, $urandom);
        drain();

        // Word write then read
        issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        drain();
        chk("t1_rdata_a", last_a, 32'hDEADBEEF);
        chk("t1_rdata_b", last_b, 32'hDEADBEEF);

        // Byte write into lane 1
        issue(1'b1, 2'd0, 32'h101, 32'h0000AB00);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        drain();
        chk("t2_rdata_a", last_a, 32'hDEADABEF);

        // Misaligned half write: completes, leaves memory unchanged
        n0a = n_dok_a;
        issue(1'b1, 2'd1, 32'h103, 32'hFFFFFFFF);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        drain();
        chk("t3_dok_count_a", n_dok_a - n0a, 2);
        chk("t3_rdata_a", last_a, 32'hDEADABEF);

        // Back-pressure: four reads back to back (B saturates at DEPTH=2)
        n0b = n_dok_b;
        for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'h100, 32'h0);
        drain();
        chk("t4_dok_count_b", n_dok_b - n0b, 4);

        // Reset with two reads in flight
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        issue(1'b0, 2'd2, 32'h100, 32'h0);
        n0a = n_dok_a; n0b = n_dok_b;
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
        for (int i = 0; i < 6; i++) idle();
        chk("t5_no_dok_a", n_dok_a - n0a, 0);
        chk("t5_no_dok_b", n_dok_b - n0b, 0);

        // Randomized traffic with aliasing upper address bits
        for (int t = 0; t < 300; t++) begin
            ad = ($urandom & 32'hFFFFC000) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ad, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
